// File: rtl/pdm_pkg.sv
// Shared constants and width helpers for the PDM capture, storage and playback path.
package pdm_pkg;

  localparam int unsigned PCM_W        = 16;
  localparam int unsigned DEF_N_STAGES = 3;
  localparam int unsigned DEF_DECIM    = 64;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // CIC register width: N*log2(R) bits of gain plus sign and input magnitude.
  function automatic int unsigned CIC_W(input int unsigned n, input int unsigned r);
    return n * clog2(r) + 2;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: y = x - x_delayed, differential delay 1, advanced by en.
module cic_comb_stage #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] x,
  output logic [W-1:0] y_c
);

  logic [W-1:0] dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      dly <= '0;
    else if (clr)   dly <= '0;
    else if (en)    dly <= x;
  end

  assign y_c = x - dly;

endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM to 16-bit PCM CIC decimator with valid/ready output and sticky overflow flag.
// Optional DC blocker after saturation when PDM_DC_BLOCK_EN is defined.
module pdm_cic_decimator
  import pdm_pkg::*;
#(
  parameter int unsigned N_STAGES   = DEF_N_STAGES,
  parameter int unsigned DECIM      = DEF_DECIM,
  parameter int unsigned DC_SHIFT_K = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pdm_ce,
  input  logic             pdm_bit,
  input  logic             capture_en,
  output logic [PCM_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             pcm_ovf
);

  localparam int unsigned LOG2_R    = clog2(DECIM);
  localparam int unsigned GAIN_BITS = N_STAGES * LOG2_R;
  localparam int unsigned W         = CIC_W(N_STAGES, DECIM);
  localparam int unsigned EW        = W + PCM_W;

  logic             adv_c;
  logic             tick_c;
  logic [W-1:0]     pdm_x_c;
  logic [LOG2_R-1:0] cnt;
  logic [W-1:0]     comb_in;
  logic             comb_go;
  logic [W-1:0]     cic_out;
  logic signed [EW-1:0] wide_c;
  logic [PCM_W-1:0] sat_c;
  logic [PCM_W-1:0] sat_q;
  logic             sat_go;
  logic [PCM_W-1:0] smp;
  logic             smp_go;
  logic             cap_q;

  assign adv_c   = pdm_ce & capture_en;
  assign tick_c  = adv_c && (cnt == LOG2_R'(DECIM - 1));
  assign pdm_x_c = pdm_bit ? W'(1) : '1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (!capture_en) cnt <= '0;
    else if (adv_c)       cnt <= cnt + 1'b1;
  end

  // Integrator cascade, one register per stage.
  for (genvar g = 0; g < N_STAGES; g++) begin : g_int
    logic [W-1:0] acc;
    logic [W-1:0] in_c;
    if (g == 0) begin : g_first
      assign in_c = pdm_x_c;
    end else begin : g_next
      assign in_c = g_int[g-1].acc;
    end
    always_ff @(posedge clk or posedge reset) begin
      if (reset)            acc <= '0;
      else if (!capture_en) acc <= '0;
      else if (adv_c)       acc <= acc + in_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      comb_in <= '0;
      comb_go <= 1'b0;
    end else if (!capture_en) begin
      comb_in <= '0;
      comb_go <= 1'b0;
    end else begin
      comb_go <= tick_c;
      if (tick_c) comb_in <= g_int[N_STAGES-1].acc;
    end
  end

  // Comb chain is combinational from comb_in; delays advance one cycle after the tick.
  for (genvar g = 0; g < N_STAGES; g++) begin : g_comb
    logic [W-1:0] x;
    logic [W-1:0] y;
    if (g == 0) begin : g_first
      assign x = comb_in;
    end else begin : g_next
      assign x = g_comb[g-1].y;
    end
    cic_comb_stage #(.W(W)) u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (comb_go),
      .clr   (!capture_en),
      .x     (x),
      .y_c   (y)
    );
  end

  assign cic_out = g_comb[N_STAGES-1].y;

  // Net arithmetic right shift of GAIN_BITS-15, done as <<<16 then >>>(GAIN_BITS+1) to stay non-negative.
  always_comb begin
    wide_c = EW'($signed(cic_out));
    wide_c = (wide_c <<< PCM_W) >>> (GAIN_BITS + 1);
    sat_c  = wide_c[PCM_W-1:0];
    if (!((&wide_c[EW-1:PCM_W-1]) || (~|wide_c[EW-1:PCM_W-1])))
      sat_c = wide_c[EW-1] ? {1'b1, {(PCM_W-1){1'b0}}} : {1'b0, {(PCM_W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_q  <= '0;
      sat_go <= 1'b0;
    end else if (!capture_en) begin
      sat_q  <= '0;
      sat_go <= 1'b0;
    end else begin
      sat_go <= comb_go;
      if (comb_go) sat_q <= sat_c;
    end
  end

`ifdef PDM_DC_BLOCK_EN
  localparam int unsigned DW = PCM_W + DC_SHIFT_K;

  logic signed [DW-1:0] dc_acc;
  logic signed [DW-1:0] dc_next_c;
  logic [PCM_W-1:0]     dc_xprev;
  logic [PCM_W-1:0]     dc_sat_c;
  logic [PCM_W-1:0]     dc_q;
  logic                 dc_go;

  // y = x - x_prev + y_prev - y_prev>>>K, kept at DW bits and saturated on the way out.
  always_comb begin
    dc_next_c = dc_acc + DW'($signed(sat_q)) - DW'($signed(dc_xprev)) - (dc_acc >>> DC_SHIFT_K);
    dc_sat_c  = dc_next_c[PCM_W-1:0];
    if (!((&dc_next_c[DW-1:PCM_W-1]) || (~|dc_next_c[DW-1:PCM_W-1])))
      dc_sat_c = dc_next_c[DW-1] ? {1'b1, {(PCM_W-1){1'b0}}} : {1'b0, {(PCM_W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dc_acc   <= '0;
      dc_xprev <= '0;
      dc_q     <= '0;
      dc_go    <= 1'b0;
    end else if (!capture_en) begin
      dc_acc   <= '0;
      dc_xprev <= '0;
      dc_q     <= '0;
      dc_go    <= 1'b0;
    end else begin
      dc_go <= sat_go;
      if (sat_go) begin
        dc_acc   <= dc_next_c;
        dc_xprev <= sat_q;
        dc_q     <= dc_sat_c;
      end
    end
  end

  assign smp    = dc_q;
  assign smp_go = dc_go;
`else
  localparam int unsigned dc_shift_unused = DC_SHIFT_K;

  assign smp    = sat_q;
  assign smp_go = sat_go;
`endif

  // Holding register: a new sample while the held one is still unaccepted is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
      pcm_ovf   <= 1'b0;
      cap_q     <= 1'b0;
    end else begin
      cap_q <= capture_en;
      if (capture_en && !cap_q) pcm_ovf <= 1'b0;
      if (smp_go) begin
        if (pcm_valid && !pcm_ready) begin
          pcm_ovf <= 1'b1;
        end else begin
          pcm_data  <= smp;
          pcm_valid <= 1'b1;
        end
      end else if (pcm_valid && pcm_ready) begin
        pcm_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator (default build, DC blocker off).
module tb_pdm_cic_decimator;

  logic        clk = 1'b0;
  logic        reset;
  logic        pdm_ce;
  logic        pdm_bit;
  logic        capture_en;
  logic [15:0] pcm_data;
  logic        pcm_valid;
  logic        pcm_ready;
  logic        pcm_ovf;

  int total = 0;
  int bad   = 0;
  int n;
  logic [15:0] got[$];

  always #5 clk = ~clk;

  pdm_cic_decimator dut (
    .clk        (clk),
    .reset      (reset),
    .pdm_ce     (pdm_ce),
    .pdm_bit    (pdm_bit),
    .capture_en (capture_en),
    .pcm_data   (pcm_data),
    .pcm_valid  (pcm_valid),
    .pcm_ready  (pcm_ready),
    .pcm_ovf    (pcm_ovf)
  );

  // Every accepted transfer is logged mid-cycle.
  always @(negedge clk) if (pcm_valid && pcm_ready) got.push_back(pcm_data);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    pdm_bit = b;
    pdm_ce  = 1'b1;
    step();
    pdm_ce  = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic strobes(input int cnt, input logic b);
    for (int i = 0; i < cnt; i++) strobe(b);
  endtask

  task automatic restart();
    capture_en = 1'b0;
    step();
    step();
    capture_en = 1'b1;
    step();
    got.delete();
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; pdm_ce = 1'b0; pdm_bit = 1'b0; capture_en = 1'b1; pcm_ready = 1'b1;
    step();
    chk("rst_data", $signed(pcm_data), 0);
    chk("rst_valid", pcm_valid, 0);
    chk("rst_ovf", pcm_ovf, 0);
    step();
    reset = 1'b0;
    step();

    // Constant ones: transients C(63,3)>>>3 and (C(127,3)-3*C(63,3))>>>3, then full scale.
    got.delete();
    strobes(256, 1'b1);
    chk("t1_count", got.size(), 4);
    chk("t1_s0", $signed(got[0]), 4963);
    chk("t1_s1", $signed(got[1]), 26780);
    chk("t1_s2", $signed(got[2]), 32767);
    chk("t1_s3", $signed(got[3]), 32767);
    chk("t1_ovf", pcm_ovf, 0);

    // Constant zeros.
    restart();
    strobes(256, 1'b0);
    chk("t2_count", got.size(), 4);
    chk("t2_s0", $signed(got[0]), -4964);
    chk("t2_s2", $signed(got[2]), -32768);
    chk("t2_s3", $signed(got[3]), -32768);

    // Alternating 1,0 with a timed fourth tick.
    restart();
    for (int i = 0; i < 255; i++) strobe((i % 2) == 0);
    pdm_bit = 1'b0;
    pdm_ce  = 1'b1;
    step();
    pdm_ce  = 1'b0;
    n = 0;
    while (!pcm_valid && n < 8) begin
      step();
      n++;
    end
    chk("t3_latency", n, 2);
    step();
    step();
    chk("t3_count", got.size(), 4);
    chk("t3_s2", $signed(got[2]), 0);
    chk("t3_s3", $signed(got[3]), 0);

    // Back-pressure across two ticks.
    restart();
    pcm_ready = 1'b0;
    strobes(64, 1'b1);
    chk("t4_valid1", pcm_valid, 1);
    chk("t4_data1", $signed(pcm_data), 4963);
    chk("t4_ovf1", pcm_ovf, 0);
    strobes(64, 1'b1);
    chk("t4_valid2", pcm_valid, 1);
    chk("t4_held", $signed(pcm_data), 4963);
    chk("t4_ovf2", pcm_ovf, 1);
    pcm_ready = 1'b1;
    step();
    chk("t4_valid_clr", pcm_valid, 0);
    chk("t4_taken_n", got.size(), 1);
    chk("t4_taken", $signed(got[0]), 4963);
    chk("t4_ovf_sticky", pcm_ovf, 1);
    capture_en = 1'b0;
    step();
    step();
    chk("t4_ovf_capoff", pcm_ovf, 1);
    capture_en = 1'b1;
    step();
    chk("t4_ovf_rise", pcm_ovf, 0);

    // capture_en drop mid-sample with a pending sample.
    got.delete();
    pcm_ready = 1'b0;
    strobes(64, 1'b1);
    strobes(30, 1'b1);
    capture_en = 1'b0;
    step();
    step();
    chk("t5_pend_valid", pcm_valid, 1);
    chk("t5_pend_data", $signed(pcm_data), 4963);
    capture_en = 1'b1;
    step();
    pcm_ready = 1'b1;
    step();
    chk("t5_pend_taken", got.size(), 1);
    strobes(63, 1'b1);
    chk("t5_no_old_tick", got.size(), 1);
    chk("t5_no_ovf", pcm_ovf, 0);
    strobe(1'b1);
    chk("t5_fresh_n", got.size(), 2);
    chk("t5_fresh", $signed(got[1]), 4963);

    // Async reset mid-sample with a held sample and overflow set.
    pcm_ready = 1'b0;
    strobes(128, 1'b1);
    chk("t6_pre_ovf", pcm_ovf, 1);
    chk("t6_pre_valid", pcm_valid, 1);
    strobes(20, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_data", $signed(pcm_data), 0);
    chk("t6_rst_valid", pcm_valid, 0);
    chk("t6_rst_ovf", pcm_ovf, 0);
    step();
    step();
    reset = 1'b0;
    pcm_ready = 1'b1;
    got.delete();
    strobes(63, 1'b1);
    chk("t6_no_partial", got.size(), 0);
    strobe(1'b1);
    chk("t6_after_n", got.size(), 1);
    chk("t6_after", $signed(got[0]), 4963);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
